// File: rtl/regfile_pkg.sv
// Shared processor constants and types for the register file and the datapath around it.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_SP   = 5'd29;
    localparam reg_idx_t REG_RA   = 5'd31;

    // A write only lands when enabled and not aimed at the hardwired zero register.
    function automatic logic is_commit(input logic we, input reg_idx_t idx);
        return we && (idx != REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Register-file port bundle: two read ports, one write port, a debug read port and write statistics.
interface regfile_if;
    import regfile_pkg::*;

    logic     reg_write;
    reg_idx_t read_reg1;
    reg_idx_t read_reg2;
    reg_idx_t write_reg;
    word_t    write_data;
    word_t    read_data1;
    word_t    read_data2;
    reg_idx_t dbg_sel;
    word_t    dbg_data;
    word_t    wr_count;
    reg_idx_t last_wr_reg;

    modport master (
        output reg_write, read_reg1, read_reg2, write_reg, write_data, dbg_sel,
        input  read_data1, read_data2, dbg_data, wr_count, last_wr_reg
    );

    modport slave (
        input  reg_write, read_reg1, read_reg2, write_reg, write_data, dbg_sel,
        output read_data1, read_data2, dbg_data, wr_count, last_wr_reg
    );
endinterface

// File: rtl/regfile.sv
// 32x32 MIPS-style register file: $0 hardwired to zero, combinational reads without write bypass,
// asynchronous reset loading $sp with SP_RESET, plus a committed-write counter and last-target register.
module regfile
    import regfile_pkg::*;
#(
    parameter word_t SP_RESET = 32'h0000_03FC
) (
    input  logic      clk,
    input  logic      rst,
    regfile_if.slave  rf
);

    word_t    regs [NUM_REGS];
    logic     commit;
    word_t    wr_count_reg;
    word_t    wr_count_next;
    reg_idx_t last_wr_idx_reg;

    assign commit = is_commit(rf.reg_write, rf.write_reg);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == REG_ZERO) begin : g_zero
                assign regs[gi] = '0;
            end else begin : g_flop
                localparam word_t RESET_VAL = (gi == REG_SP) ? SP_RESET : '0;
                word_t q_reg;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        q_reg <= RESET_VAL;
                    end else if (commit && (rf.write_reg == reg_idx_t'(gi))) begin
                        q_reg <= rf.write_data;
                    end
                end

                assign regs[gi] = q_reg;
            end
        end
    endgenerate

    // Wraps naturally at 2^32.
    assign wr_count_next = wr_count_reg + word_t'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count_reg    <= '0;
            last_wr_idx_reg <= REG_ZERO;
        end else if (commit) begin
            wr_count_reg    <= wr_count_next;
            last_wr_idx_reg <= rf.write_reg;
        end
    end

    // Reads show the pre-edge contents; a same-cycle write is visible only after the edge.
    assign rf.read_data1  = regs[rf.read_reg1];
    assign rf.read_data2  = regs[rf.read_reg2];
    assign rf.dbg_data    = regs[rf.dbg_sel];
    assign rf.wr_count    = wr_count_reg;
    assign rf.last_wr_reg = last_wr_idx_reg;

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL have parameter SP_RESET, default 32'h0000_03FC, reset value of register $29 ($sp).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port reg_write  input  1  write enable from the control unit.
REQ-005 SHALL have port read_reg1  input  5  rs address.
REQ-006 SHALL have port read_reg2  input  5  rt address.
REQ-007 SHALL have port write_reg  input  5  destination address, driven by the RegDst multiplexer output.
REQ-008 SHALL have port write_data  input  32  value to write, from the MemtoReg multiplexer.
REQ-009 SHALL have port read_data1  output  32  contents of read_reg1.
REQ-010 SHALL have port read_data2  output  32  contents of read_reg2.
REQ-011 SHALL have port dbg_sel  input  5  debug/board-display read address.
REQ-012 SHALL have port dbg_data  output  32  contents of dbg_sel.
REQ-013 SHALL have port wr_count  output  32  number of committed writes since reset.
REQ-014 SHALL have port last_wr_reg  output  5  address of the most recent committed write.

Function
REQ-015 SHALL hold 32 registers of 32 bits; $0 SHALL always read 32'h0000_0000 and never be written.
REQ-016 SHALL drive read_data1, read_data2, dbg_data combinationally from the register array (zero latency, no clock involvement).
REQ-017 SHALL commit a write (register[write_reg] <= write_data) on the rising clk edge only when reg_write=1 and write_reg!=0.
REQ-018 SHALL return the pre-edge (old) value on a read whose address equals write_reg in the same cycle; the new value appears after the edge; no write-through bypass (avoids a combinational loop in the single-cycle datapath).
REQ-019 SHALL ignore write_data entirely when reg_write=0.
REQ-020 SHALL treat reg_write=1 with write_reg=0 as a no-op: no register change, wr_count and last_wr_reg unchanged.
REQ-021 SHALL increment wr_count by 1 on every committed write, modulo 2^32 (32'hFFFF_FFFF wraps to 0).
REQ-022 SHALL load last_wr_reg with write_reg on every committed write, else hold.
REQ-023 SHALL allow read_reg1, read_reg2 and dbg_sel to address the same register simultaneously, all returning identical values.
REQ-024 SHALL have no X on any output after reset regardless of input values.

Reset
REQ-025 SHALL, while rst=1, immediately and asynchronously set registers $1-$28 and $30-$31 to 0, $29 to SP_RESET, wr_count to 0, last_wr_reg to 0.
REQ-026 SHALL give rst priority over any write on the same edge; a write presented while rst=1 is discarded.
REQ-027 SHALL resume normal writes on the first rising clk edge after rst deasserts.

Structure
REQ-028 SHALL take register-index constants (REG_ZERO=0, REG_SP=29, REG_RA=31) and data width 32 from the shared processor package/defines file used by the datapath.
REQ-029 SHALL be a single flat module; no sub-modules (array plus counter do not justify one).
REQ-030 SHALL connect write_reg directly to the RegDst multiplexer result in the top-level datapath.

Verification
REQ-031 Reset: rst=1 mid-run -> all reads 0 except $29=32'h0000_03FC; wr_count=0; last_wr_reg=0, without a clk edge.
REQ-032 Write/read: reg_write=1, write_reg=8, write_data=32'hDEAD_BEEF, edge -> read_reg1=8 gives 32'hDEAD_BEEF; wr_count=1; last_wr_reg=8.
REQ-033 $0 protection: reg_write=1, write_reg=0, write_data=32'hFFFF_FFFF, edge -> read $0 = 0; wr_count unchanged.
REQ-034 Same-cycle read/write: $9=5, then write_reg=9, write_data=7, read_reg2=9 -> read_data2=5 before edge, 7 after.
REQ-035 Counter wrap: force wr_count to 32'hFFFF_FFFF, one committed write -> wr_count=0.
REQ-036 Disabled write and reset collision: reg_write=0, write_reg=10, write_data=1 -> $10 unchanged; rst=1 with reg_write=1, write_reg=10 -> $10=0 after edge.
